// File: rtl/ram_master_pkg.sv
// Shared opcodes, FSM state encoding and default widths
// for the RAM block master.
package ram_master_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 16;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_COPY  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    RSP,
    FILL,
    CP_RD,
    CP_WR,
    DONE
  } state_e;

endpackage

// File: rtl/ram_addr_gen.sv
// Wrapping address walker: loads a base and a word count,
// steps one word at a time and flags the final word.
module ram_addr_gen #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W:0] rem;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr <= '0;
      rem  <= '0;
    end else if (load) begin
      addr <= base;
      rem  <= count;
    end else if (step) begin
      addr <= addr + ADDR_W'(1);
      rem  <= rem - (ADDR_W+1)'(1);
    end
  end

  assign last = (rem == (ADDR_W+1)'(1));

endmodule

// File: rtl/ram_block_master.sv
// Command-driven RAM master: WRITE, READ, FILL, COPY.
// Define RAM_BLOCK_MASTER_CHECKSUM_EN to add the chk_sum output.
module ram_block_master
  import ram_master_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_addr2,
  input  logic [ADDR_W:0]   cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              rsp_ready,
  output logic              done,
`ifdef RAM_BLOCK_MASTER_CHECKSUM_EN
  output logic [DATA_W-1:0] chk_sum,
`endif
  output logic [ADDR_W-1:0] ram_add,
  output logic [DATA_W-1:0] ram_in,
  input  logic [DATA_W-1:0] ram_out,
  output logic              ram_read,
  output logic              ram_write,
  output logic              ram_en
);

  state_e            state;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] hold;
  logic              accept;
  logic              src_step;
  logic              dst_step;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic              src_last;
  logic              dst_last;
  logic              len_zero;

  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RSP);
  assign done      = (state == DONE);
  assign accept    = cmd_ready && cmd_valid;
  assign src_step  = (state == FILL) || (state == CP_RD);
  assign dst_step  = (state == CP_WR);
  assign len_zero  = (cmd_len == '0);

  ram_addr_gen #(.ADDR_W(ADDR_W)) u_src (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .step  (src_step),
    .base  (cmd_addr),
    .count (cmd_len),
    .addr  (src_addr),
    .last  (src_last)
  );

  ram_addr_gen #(.ADDR_W(ADDR_W)) u_dst (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .step  (dst_step),
    .base  (cmd_addr2),
    .count (cmd_len),
    .addr  (dst_addr),
    .last  (dst_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      data_q   <= '0;
      hold     <= '0;
      rsp_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            data_q <= cmd_data;
            unique case (cmd_op)
              OP_WRITE: state <= WR;
              OP_READ:  state <= RD;
              OP_FILL:  state <= len_zero ? DONE : FILL;
              OP_COPY:  state <= len_zero ? DONE : CP_RD;
            endcase
          end
        end
        WR: state <= DONE;
        RD: begin
          rsp_data <= ram_out;
          state    <= RSP;
        end
        RSP: if (rsp_ready) state <= DONE;
        FILL: begin
          data_q <= data_q + DATA_W'(1);
          if (src_last) state <= DONE;
        end
        CP_RD: begin
          hold  <= ram_out;
          state <= CP_WR;
        end
        CP_WR: state <= dst_last ? DONE : CP_RD;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes and RAM bus depend on state alone; idle bus is all zero
  always_comb begin
    ram_en    = 1'b0;
    ram_read  = 1'b0;
    ram_write = 1'b0;
    ram_add   = '0;
    ram_in    = '0;
    unique case (state)
      WR, FILL: begin
        ram_en    = 1'b1;
        ram_write = 1'b1;
        ram_add   = src_addr;
        ram_in    = data_q;
      end
      RD, CP_RD: begin
        ram_en   = 1'b1;
        ram_read = 1'b1;
        ram_add  = src_addr;
      end
      CP_WR: begin
        ram_en    = 1'b1;
        ram_write = 1'b1;
        ram_add   = dst_addr;
        ram_in    = hold;
      end
      default: ;
    endcase
  end

`ifdef RAM_BLOCK_MASTER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (accept) begin
      sum_q <= '0;
    end else if (state == RD || state == CP_RD) begin
      sum_q <= sum_q + ram_out;
    end
  end

  assign chk_sum = sum_q;
`endif

endmodule

// File: tb/tb_ram_block_master.sv
// Bench for ram_block_master: directed table, corner
// sequences and random commands against a memory model.
module tb_ram_block_master;

  localparam int AW    = 12;
  localparam int DW    = 16;
  localparam int DEPTH = 4096;

  localparam logic [1:0] C_WR = 2'd0;
  localparam logic [1:0] C_RD = 2'd1;
  localparam logic [1:0] C_FL = 2'd2;
  localparam logic [1:0] C_CP = 2'd3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic [AW-1:0] cmd_addr2 = '0;
  logic [AW:0]   cmd_len = '0;
  logic [DW-1:0] cmd_data = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_ready = 1'b1;
  logic          done;
  logic [AW-1:0] ram_add;
  logic [DW-1:0] ram_in;
  logic [DW-1:0] ram_out;
  logic          ram_read;
  logic          ram_write;
  logic          ram_en;
`ifdef RAM_BLOCK_MASTER_CHECKSUM_EN
  logic [DW-1:0] chk_sum;
`endif

  always #5 clk = ~clk;

  ram_block_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_addr2 (cmd_addr2),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .done      (done),
`ifdef RAM_BLOCK_MASTER_CHECKSUM_EN
    .chk_sum   (chk_sum),
`endif
    .ram_add   (ram_add),
    .ram_in    (ram_in),
    .ram_out   (ram_out),
    .ram_read  (ram_read),
    .ram_write (ram_write),
    .ram_en    (ram_en)
  );

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic          clear_mem = 1'b1;

  always @(posedge clk) begin
    if (clear_mem) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (ram_en && ram_write) begin
      mem[ram_add] <= ram_in;
    end
  end

  assign ram_out = (ram_en && ram_read) ? mem[ram_add] : '0;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference memory: applies a whole command at once
  task automatic apply_ref(input logic [1:0] op,
                           input logic [AW-1:0] a,
                           input logic [AW-1:0] a2,
                           input logic [AW:0] len,
                           input logic [DW-1:0] d,
                           output logic [DW-1:0] rsp,
                           output logic [DW-1:0] sum);
    logic [DW-1:0] v;
    rsp = '0;
    sum = '0;
    case (op)
      C_WR: ref_mem[a] = d;
      C_RD: begin
        rsp = ref_mem[a];
        sum = rsp;
      end
      C_FL:
        for (int i = 0; i < int'(len); i++)
          ref_mem[(int'(a) + i) % DEPTH] = d + DW'(i);
      default:
        for (int i = 0; i < int'(len); i++) begin
          v = ref_mem[(int'(a) + i) % DEPTH];
          sum = sum + v;
          ref_mem[(int'(a2) + i) % DEPTH] = v;
        end
    endcase
  endtask

  function automatic int lat_of(input logic [1:0] op,
                                input logic [AW:0] len);
    case (op)
      C_WR:    return 2;
      C_RD:    return 3;
      C_FL:    return (len == 0) ? 1 : int'(len) + 1;
      default: return (len == 0) ? 1 : 2 * int'(len) + 1;
    endcase
  endfunction

  function automatic int strobes_of(input logic [1:0] op,
                                    input logic [AW:0] len);
    case (op)
      C_WR, C_RD: return 1;
      C_FL:       return int'(len);
      default:    return 2 * int'(len);
    endcase
  endfunction

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_ready_to"}, 32'(n < 50), 32'd1);
  endtask

  // Issue one command with rsp_ready high and measure it
  task automatic run_cmd(input logic [1:0] op,
                         input logic [AW-1:0] a,
                         input logic [AW-1:0] a2,
                         input logic [AW:0] len,
                         input logic [DW-1:0] d,
                         input int exp_lat,
                         input int exp_str,
                         input logic [DW-1:0] exp_rsp,
                         input logic chk_rsp,
                         input logic [DW-1:0] exp_sum,
                         input string tag);
    int lat, str, alt_bad, both;
    logic [DW-1:0] got;
    logic seen;
    cmd_op = op;
    cmd_addr = a;
    cmd_addr2 = a2;
    cmd_len = len;
    cmd_data = d;
    cmd_valid = 1'b1;
    wait_ready(tag);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    lat = 1;
    str = 0;
    alt_bad = 0;
    both = 0;
    seen = 1'b0;
    got = '0;
    while (!done && lat < 10000) begin
      if (ram_read && ram_write) both++;
      if (ram_en) begin
        if (op == C_CP && ram_read != ((str % 2) == 0)) alt_bad++;
        str++;
      end
      if (rsp_valid && !seen) begin
        got = rsp_data;
        seen = 1'b1;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_strobes"}, 32'(str), 32'(exp_str));
    check({tag, "_rw_excl"}, 32'(both + alt_bad), 32'd0);
    if (chk_rsp) check({tag, "_rsp"}, 32'(got), 32'(exp_rsp));
`ifdef RAM_BLOCK_MASTER_CHECKSUM_EN
    check({tag, "_chk_sum"}, 32'(chk_sum), 32'(exp_sum));
`else
    if (exp_sum === 'x) $display("note: %s unknown sum", tag);
`endif
    @(posedge clk);
    #1;
    check({tag, "_next_ready"}, {30'd0, cmd_ready, done}, 32'd2);
  endtask

  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] a;
    logic [AW-1:0] a2;
    logic [AW:0]   len;
    logic [DW-1:0] d;
    int            lat;
    int            str;
    logic [DW-1:0] rsp;
    logic          chk;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [DW-1:0] r, s, held;
    int n, nbad;
    tbl[0]  = '{C_WR, 12'h0A5, 12'h000, 13'd0, 16'hBEEF, 2, 1, 16'h0000, 1'b0};
    tbl[1]  = '{C_RD, 12'h0A5, 12'h000, 13'd0, 16'h0000, 3, 1, 16'hBEEF, 1'b1};
    tbl[2]  = '{C_FL, 12'hFFE, 12'h000, 13'd4, 16'hFFFF, 5, 4, 16'h0000, 1'b0};
    tbl[3]  = '{C_RD, 12'hFFF, 12'h000, 13'd0, 16'h0000, 3, 1, 16'h0000, 1'b1};
    tbl[4]  = '{C_RD, 12'h001, 12'h000, 13'd0, 16'h0000, 3, 1, 16'h0002, 1'b1};
    tbl[5]  = '{C_FL, 12'h010, 12'h000, 13'd3, 16'h1234, 4, 3, 16'h0000, 1'b0};
    tbl[6]  = '{C_CP, 12'h010, 12'h200, 13'd3, 16'h0000, 7, 6, 16'h0000, 1'b0};
    tbl[7]  = '{C_RD, 12'h202, 12'h000, 13'd0, 16'h0000, 3, 1, 16'h1236, 1'b1};
    tbl[8]  = '{C_FL, 12'h020, 12'h000, 13'd0, 16'h7777, 1, 0, 16'h0000, 1'b0};
    tbl[9]  = '{C_WR, 12'h400, 12'h000, 13'd0, 16'h8000, 2, 1, 16'h0000, 1'b0};
    tbl[10] = '{C_WR, 12'h401, 12'h000, 13'd0, 16'h8001, 2, 1, 16'h0000, 1'b0};
    tbl[11] = '{C_CP, 12'h400, 12'h500, 13'd2, 16'h0000, 5, 4, 16'h0000, 1'b0};
    tbl[12] = '{C_RD, 12'h501, 12'h000, 13'd0, 16'h0000, 3, 1, 16'h8001, 1'b1};
    tbl[13] = '{C_FL, 12'h800, 12'h000, 13'd4096, 16'h0100, 4097, 4096,
                16'h0000, 1'b0};
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_outs", {rsp_valid, done, ram_en, ram_read, ram_write},
          32'd0);
    check("rst_bus", {ram_add, ram_in}, 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    rst_n = 1'b1;
    clear_mem = 1'b0;

    for (int i = 0; i < 14; i++) begin
      apply_ref(tbl[i].op, tbl[i].a, tbl[i].a2, tbl[i].len, tbl[i].d, r, s);
      run_cmd(tbl[i].op, tbl[i].a, tbl[i].a2, tbl[i].len, tbl[i].d,
              tbl[i].lat, tbl[i].str, tbl[i].rsp, tbl[i].chk, s,
              $sformatf("vec%0d", i));
    end

    // READ held off by rsp_ready low for 10 cycles
    rsp_ready = 1'b0;
    cmd_op = C_RD;
    cmd_addr = 12'h0A5;
    cmd_valid = 1'b1;
    wait_ready("hold");
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("hold_rsp_to", 32'(n < 20), 32'd1);
    held = ref_mem[12'h0A5];
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("hold_stable", {rsp_valid, cmd_ready, done, 13'd0, rsp_data},
            {3'b100, 13'd0, held});
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hold_done", {30'd0, done, rsp_valid}, 32'd2);
    @(posedge clk);
    #1;

    // Reset partway through an 8-word FILL
    cmd_op = C_FL;
    cmd_addr = 12'h300;
    cmd_len = 13'd8;
    cmd_data = 16'h5550;
    cmd_valid = 1'b1;
    wait_ready("rstfill");
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("rstfill_nodone", 32'(done), 32'd0);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rstfill_outs", {done, rsp_valid, ram_en, ram_read, ram_write},
          32'd0);
    check("rstfill_bus", {ram_add, ram_in}, 32'd0);
    check("rstfill_ready", 32'(cmd_ready), 32'd1);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) ref_mem[12'h300 + i] = 16'h5550 + DW'(i);
    @(posedge clk);
    #1;
    check("rstfill_nodone2", 32'(done), 32'd0);
    for (int i = 0; i < 8; i++)
      check($sformatf("rstfill_w%0d", i), 32'(mem[12'h300 + i]),
            32'(ref_mem[12'h300 + i]));

    for (int k = 0; k < 40; k++) begin
      logic [1:0]    op;
      logic [AW-1:0] a, a2;
      logic [AW:0]   len;
      logic [DW-1:0] d;
      op = 2'($urandom);
      a = AW'($urandom);
      a2 = AW'($urandom);
      len = (AW+1)'($urandom_range(0, 24));
      d = DW'($urandom);
      apply_ref(op, a, a2, len, d, r, s);
      run_cmd(op, a, a2, len, d, lat_of(op, len), strobes_of(op, len),
              r, op == C_RD, s, $sformatf("rnd%0d", k));
    end

    nbad = 0;
    for (int i = 0; i < DEPTH; i++)
      if (mem[i] !== ref_mem[i]) nbad++;
    check("mem_final", 32'(nbad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
